theta_checker: RTL and testbench
================================

THETA_CHECKER -- requirements
Module: theta_checker

Interface
REQ-001 Parameter NSLICE, default 64, gives the number of 25-bit slices per state; the counter width is 6 for the default.
REQ-002 Parameter CNTW, default 7, gives the width of err_count, and SHALL be able to hold NSLICE.
REQ-003 clk  input  1  rising-edge clock; the block uses one clock only.
REQ-004 rst  input  1  reset; asynchronous and active-low (0 = reset).
REQ-005 start  input  1  begins a check run; sampled only in IDLE.
REQ-006 in_valid  input  1  slice_in/res_in beat valid.
REQ-007 in_ready  output  1  block accepts a beat; a beat transfers when in_valid&&in_ready at a rising edge.
REQ-008 slice_in  input  25  original state slice z; bit i = x+5*y, with x,y in 0..4.
REQ-009 res_in  input  25  theta result under test for the same slice z.
REQ-010 busy  output  1  high in RUN and WRAP.
REQ-011 done  output  1  one-cycle pulse when a run completes.
REQ-012 pass  output  1  1 when the last completed run had zero mismatches.
REQ-013 err_count  output  CNTW  number of mismatching slices in the last or current run.
REQ-014 first_err_idx  output  6  smallest z that mismatched; valid when err_count!=0.

Function
REQ-015 FSM states SHALL be IDLE, RUN, WRAP and DONE.
REQ-016 IDLE: start=1 clears err_count, first_err_idx and the slice counter z, then goes to RUN.
REQ-017 start SHALL be ignored in all states other than IDLE.
REQ-018 in_ready SHALL be 1 only in RUN; in_valid outside RUN has no effect.
REQ-019 Each accepted beat SHALL compute column parity C_z[x] = XOR over y of slice_in[x+5y], and register C_z as prev_par.
REQ-020 The expected result is exp[x+5y] = slice_in[x+5y] ^ C_z[(x+4)%5] ^ C_{z-1}[(x+1)%5], where z-1 wraps so that z=0 uses C_{NSLICE-1}.
REQ-021 For z>=1, the beat SHALL be compared at acceptance (exp vs res_in) using prev_par; err_count increments at the same edge on mismatch.
REQ-022 For z=0, the block SHALL store slice_in and res_in in 25-bit holding registers and defer the compare.
REQ-023 After beat z=NSLICE-1 is accepted at edge k, the FSM SHALL enter WRAP.
REQ-024 At edge k+1, WRAP SHALL compare the held slice 0 using C_{NSLICE-1} from prev_par, update the counters, and go to DONE.
REQ-025 DONE SHALL assert done for exactly one cycle (the cycle after edge k+1) and then return to IDLE.
REQ-026 pass SHALL be updated to (final err_count==0) on entry to DONE.
REQ-027 first_err_idx SHALL be updated on a mismatch at z>=1 only when err_count was 0; a z=0 mismatch in WRAP always overwrites it with 0.
REQ-028 A gap in in_valid SHALL stall RUN with no state change; the throughput is one beat per cycle.
REQ-029 err_count, pass and first_err_idx SHALL hold after DONE until the next accepted start.
REQ-030 err_count SHALL NOT wrap, because it can count up to NSLICE.

Reset
REQ-031 With rst=0, asynchronously: FSM=IDLE, in_ready=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=0, z=0, prev_par=0, holding registers=0.
REQ-032 Reset asserted mid-run SHALL abort the run with no done pulse; after release, the block waits in IDLE for start.

Verification
REQ-033 All-zero state and all-zero res for 64 beats -> done 2 cycles after the last beat, pass=1, err_count=0.
REQ-034 Single bit at z=5, bit0 set; res5 = 0x0210843 (bits 0,1,6,11,16,21), res6 = 0x1084210 (bits 4,9,14,19,24), others 0 -> pass=1.
REQ-035 Single bit at z=63, bit0 set; res63 = 0x0210843, res0 = 0x1084210 (wrap case) -> pass=1; res0=0 instead -> err_count=1, first_err_idx=0.
REQ-036 Zero state with res10=1 and res20=1 -> err_count=2, first_err_idx=10, pass=0.
REQ-037 Random in_valid gaps, plus start pulsed during RUN -> results identical to gap-free reference and start ignored; rst pulled low at beat 30 -> outputs zero, no done, and a new run afterwards passes.

Source files
------------

// File: rtl/theta_checker.sv
// Theta-step checker: streams 25-bit Keccak-style slices with a claimed theta
// result for each, and counts the slices whose result disagrees with the
// recomputed one. Slice 0 needs the column parity of the last slice, so its
// compare is deferred to a single WRAP cycle at the end of the run.
module theta_checker #(
    parameter int NSLICE = 64,
    parameter int CNTW   = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [24:0]     slice_in,
    input  logic [24:0]     res_in,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [CNTW-1:0] err_count,
    output logic [5:0]      first_err_idx
);

    localparam int ZW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [ZW-1:0] Z_LAST = ZW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WRAP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [ZW-1:0]   z_q, z_d;
    logic [4:0]      prev_par_q, prev_par_d;
    logic [24:0]     hold_s_q, hold_s_d;
    logic [24:0]     hold_r_q, hold_r_d;
    logic [CNTW-1:0] err_q, err_d;
    logic [5:0]      fei_q, fei_d;
    logic            pass_q, pass_d;

    logic [4:0]      beat_par;
    logic            beat_miss;
    logic            wrap_miss;

    // Column parity C[x] = XOR over the five rows of a slice.
    function automatic logic [4:0] col_par(input logic [24:0] s);
        logic [4:0] c;
        for (int x = 0; x < 5; x++) begin
            c[x] = s[x] ^ s[x+5] ^ s[x+10] ^ s[x+15] ^ s[x+20];
        end
        return c;
    endfunction

    // Theta result for one slice given this slice's and the previous slice's parity.
    function automatic logic [24:0] theta_exp(input logic [24:0] s,
                                              input logic [4:0]  c_cur,
                                              input logic [4:0]  c_prev);
        logic [24:0] r;
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                r[x+5*y] = s[x+5*y] ^ c_cur[(x+4)%5] ^ c_prev[(x+1)%5];
            end
        end
        return r;
    endfunction

    // Compare results for the incoming beat and for the held slice 0.
    always_comb begin
        beat_par  = col_par(slice_in);
        beat_miss = (theta_exp(slice_in, beat_par, prev_par_q) != res_in);
        wrap_miss = (theta_exp(hold_s_q, col_par(hold_s_q), prev_par_q) != hold_r_q);
    end

    // Next-state and datapath update.
    always_comb begin
        state_d    = state_q;
        z_d        = z_q;
        prev_par_d = prev_par_q;
        hold_s_d   = hold_s_q;
        hold_r_d   = hold_r_q;
        err_d      = err_q;
        fei_d      = fei_q;
        pass_d     = pass_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    err_d   = '0;
                    fei_d   = '0;
                    z_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (in_valid) begin
                    prev_par_d = beat_par;
                    if (z_q == '0) begin
                        hold_s_d = slice_in;
                        hold_r_d = res_in;
                    end else if (beat_miss) begin
                        err_d = err_q + CNTW'(1);
                        if (err_q == '0) begin
                            fei_d = 6'(z_q);
                        end
                    end
                    if (z_q == Z_LAST) begin
                        state_d = WRAP;
                    end else begin
                        z_d = z_q + ZW'(1);
                    end
                end
            end
            WRAP: begin
                // prev_par now holds the parity of the last slice, which slice 0 wraps to.
                if (wrap_miss) begin
                    err_d = err_q + CNTW'(1);
                    fei_d = '0;
                end
                pass_d  = (err_d == '0);
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            z_q        <= '0;
            prev_par_q <= '0;
            hold_s_q   <= '0;
            hold_r_q   <= '0;
            err_q      <= '0;
            fei_q      <= '0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            z_q        <= z_d;
            prev_par_q <= prev_par_d;
            hold_s_q   <= hold_s_d;
            hold_r_q   <= hold_r_d;
            err_q      <= err_d;
            fei_q      <= fei_d;
            pass_q     <= pass_d;
        end
    end

    assign in_ready      = (state_q == RUN);
    assign busy          = (state_q == RUN) || (state_q == WRAP);
    assign done          = (state_q == DONE);
    assign pass          = pass_q;
    assign err_count     = err_q;
    assign first_err_idx = fei_q;

endmodule

// File: tb/tb_theta_checker.sv
// Bench for theta_checker: whole-state theta model, directed runs, gap/start
// stress and a mid-run reset.
module tb_theta_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [24:0] slice_in;
    logic [24:0] res_in;
    logic        busy;
    logic        done;
    logic        pass;
    logic [6:0]  err_count;
    logic [5:0]  first_err_idx;

    logic [24:0] s_arr [64];
    logic [24:0] r_arr [64];
    int          exp_err;
    int          exp_fei;
    int          exp_pass;
    int          done_seen;
    int          done_want;
    int          n_vec;
    int          n_miss;

    theta_checker #(.NSLICE(64), .CNTW(7)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .slice_in      (slice_in),
        .res_in        (res_in),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_err_idx (first_err_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Parity of column x over the whole slice, bit by bit.
    function automatic logic [4:0] m_par(input logic [24:0] s);
        logic [4:0] c = '0;
        for (int i = 0; i < 25; i++) c[i % 5] = c[i % 5] ^ s[i];
        return c;
    endfunction

    // Correct theta output for slice z of the stored state.
    function automatic logic [24:0] m_theta(input int z);
        logic [4:0]  cz = m_par(s_arr[z]);
        logic [4:0]  cp = m_par(s_arr[(z + 63) % 64]);
        logic [24:0] r;
        for (int i = 0; i < 25; i++) begin
            r[i] = s_arr[z][i] ^ cz[(i % 5 + 4) % 5] ^ cp[(i % 5 + 1) % 5];
        end
        return r;
    endfunction

    task automatic m_score();
        exp_err = 0;
        exp_fei = 0;
        for (int z = 0; z < 64; z++) begin
            if (m_theta(z) != r_arr[z]) begin
                if (exp_err == 0) exp_fei = z;
                exp_err++;
            end
        end
        exp_pass = (exp_err == 0) ? 1 : 0;
    endtask

    task automatic clear_state();
        for (int z = 0; z < 64; z++) begin
            s_arr[z] = '0;
            r_arr[z] = '0;
        end
    endtask

    // Result checker: runs on every completion pulse.
    always @(negedge clk) begin
        if (rst && done) begin
            done_seen++;
            chk("err_count", {25'd0, err_count}, exp_err);
            if (exp_err != 0) chk("first_err_idx", {26'd0, first_err_idx}, exp_fei);
            chk("pass", {31'd0, pass}, exp_pass);
            chk("busy_in_done", {31'd0, busy}, 0);
        end
    end

    // Called #1 after a rising edge with the DUT in IDLE.
    task automatic run(input int gap_pct, input bit poke, input int abort_at);
        int z = 0;
        int guard = 0;
        bit fire;
        m_score();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 1);
        while (z < 64 && guard < 5000) begin
            if (z == abort_at) begin
                in_valid = 1'b0;
                rst = 1'b0;
                #1;
                chk("abort_busy", {31'd0, busy}, 0);
                chk("abort_ready", {31'd0, in_ready}, 0);
                chk("abort_err", {25'd0, err_count}, 0);
                chk("abort_fei", {26'd0, first_err_idx}, 0);
                chk("abort_pass", {31'd0, pass}, 0);
                repeat (3) begin
                    @(posedge clk); #1;
                    chk("abort_no_done", {31'd0, done}, 0);
                end
                rst = 1'b1;
                repeat (3) begin
                    @(posedge clk); #1;
                    chk("abort_idle", {30'd0, busy, done}, 0);
                end
                return;
            end
            in_valid = (gap_pct == 0) ? 1'b1 : ($urandom_range(99) >= gap_pct);
            slice_in = s_arr[z];
            res_in   = r_arr[z];
            start    = poke && ($urandom_range(5) == 0);
            fire     = in_valid && in_ready;
            @(posedge clk); #1;
            guard++;
            if (fire) z++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (z < 64) begin
            chk("beat_timeout", z, 64);
            return;
        end
        chk("wrap_busy", {31'd0, busy}, 1);
        chk("wrap_ready", {31'd0, in_ready}, 0);
        chk("wrap_done", {31'd0, done}, 0);
        done_want++;
        @(posedge clk); #1;
        chk("done_pulse", {31'd0, done}, 1);
        @(posedge clk); #1;
        chk("done_cleared", {31'd0, done}, 0);
        chk("idle_busy", {31'd0, busy}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_vec = 0; n_miss = 0; done_seen = 0; done_want = 0;
        exp_err = 0; exp_fei = 0; exp_pass = 0;
        start = 1'b0; in_valid = 1'b0; slice_in = '0; res_in = '0;
        #1 rst = 1'b0;
        #2;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_ready", {31'd0, in_ready}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_pass", {31'd0, pass}, 0);
        chk("rst_err", {25'd0, err_count}, 0);
        chk("rst_fei", {26'd0, first_err_idx}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // All-zero state and result.
        clear_state();
        run(0, 1'b0, -1);
        chk("zero_pass", {31'd0, pass}, 1);
        chk("zero_err", {25'd0, err_count}, 0);

        // Single bit at z=5.
        clear_state();
        s_arr[5] = 25'h1;
        chk("model_pin_z5", m_theta(5), 25'h0210843);
        chk("model_pin_z6", m_theta(6), 25'h1084210);
        r_arr[5] = 25'h0210843;
        r_arr[6] = 25'h1084210;
        run(0, 1'b0, -1);
        chk("z5_pass", {31'd0, pass}, 1);

        // Single bit at z=63, result wraps onto slice 0.
        clear_state();
        s_arr[63] = 25'h1;
        r_arr[63] = 25'h0210843;
        r_arr[0]  = 25'h1084210;
        run(0, 1'b0, -1);
        chk("z63_pass", {31'd0, pass}, 1);
        r_arr[0] = 25'h0;
        run(0, 1'b0, -1);
        chk("z63_bad_err", {25'd0, err_count}, 1);
        chk("z63_bad_fei", {26'd0, first_err_idx}, 0);
        chk("z63_bad_pass", {31'd0, pass}, 0);

        // Zero state, corrupt results at z=10 and z=20.
        clear_state();
        r_arr[10] = 25'h1;
        r_arr[20] = 25'h1;
        run(0, 1'b0, -1);
        chk("two_err", {25'd0, err_count}, 2);
        chk("two_fei", {26'd0, first_err_idx}, 10);
        chk("two_pass", {31'd0, pass}, 0);

        // Outside RUN, in_valid and data are ignored and results hold.
        in_valid = 1'b1;
        slice_in = 25'h1555555;
        res_in   = 25'h0aaaaaa;
        repeat (6) begin
            @(posedge clk); #1;
            chk("idle_ready", {31'd0, in_ready}, 0);
        end
        in_valid = 1'b0;
        chk("hold_err", {25'd0, err_count}, 2);
        chk("hold_fei", {26'd0, first_err_idx}, 10);
        chk("hold_pass", {31'd0, pass}, 0);

        // Random state with errors at z=0, 3 and 40; gap-free then gapped with start pokes.
        for (int z = 0; z < 64; z++) s_arr[z] = 25'($urandom);
        for (int z = 0; z < 64; z++) r_arr[z] = m_theta(z);
        r_arr[3]  = r_arr[3]  ^ 25'h0000004;
        r_arr[40] = r_arr[40] ^ 25'h1000000;
        r_arr[0]  = r_arr[0]  ^ 25'h0000100;
        run(0, 1'b0, -1);
        chk("rand_err", {25'd0, err_count}, 3);
        chk("rand_fei", {26'd0, first_err_idx}, 0);
        run(40, 1'b1, -1);
        chk("rand_gap_err", {25'd0, err_count}, 3);
        chk("rand_gap_fei", {26'd0, first_err_idx}, 0);
        r_arr[0] = m_theta(0);
        run(50, 1'b1, -1);
        chk("rand_gap_fei3", {26'd0, first_err_idx}, 3);

        // Reset at beat 30, then a clean run.
        clear_state();
        r_arr[12] = 25'h2;
        run(0, 1'b0, 30);
        clear_state();
        run(0, 1'b0, -1);
        chk("post_abort_pass", {31'd0, pass}, 1);
        chk("post_abort_err", {25'd0, err_count}, 0);

        chk("done_count", done_seen, done_want);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
